// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial front end for the single-bit stream consumed by the
//   downstream four-ones detector. Accepts WIDTH-bit words over a
//   valid/ready handshake and shifts them out one bit per clock on `data`.
//   A one-word holding register lets consecutive words stream without gaps.
//   When nothing is in flight `data` is held at 0.
//
// Parameters
//   WIDTH     : word width in bits (>= 2)
//   MSB_FIRST : 1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   in_valid : upstream word present
//   in_data  : upstream word, sampled only on accept
//   in_ready : block can accept a word this cycle
//   data     : serial bit stream
//   last     : high while `data` carries the final bit of a word
//   busy     : a word is shifting or a word is held
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             data,
  output logic             last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hb;
  logic             hold_valid;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             shifter_free;
  logic             active;
  logic [WIDTH-1:0] sr_next_shift;
  logic             sr_out;

  assign active       = (state == SHIFT);
  assign in_ready     = ~hold_valid & ~rst;
  assign accept       = in_valid & in_ready;
  // The shifter can take a new word when idle or when its final bit ends now.
  assign shifter_free = ~active | (cnt == CNT_LAST);

  always_comb begin
    sr_next_shift = '0;
    sr_out        = 1'b0;
    if (MSB_FIRST) begin
      sr_next_shift = {sr[WIDTH-2:0], 1'b0};
      sr_out        = sr[WIDTH-1];
    end else begin
      sr_next_shift = {1'b0, sr[WIDTH-1:1]};
      sr_out        = sr[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      hb         <= '0;
      hold_valid <= 1'b0;
    end else if (shifter_free && hold_valid) begin
      // Drain the holding register; a word arriving on the same edge refills it.
      state      <= SHIFT;
      cnt        <= '0;
      sr         <= hb;
      hold_valid <= accept;
      if (accept) begin
        hb <= in_data;
      end
    end else if (shifter_free && accept) begin
      state <= SHIFT;
      cnt   <= '0;
      sr    <= in_data;
    end else if (shifter_free) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
      sr  <= sr_next_shift;
      if (accept) begin
        hb         <= in_data;
        hold_valid <= 1'b1;
      end
    end
  end

  assign data = active & sr_out;
  assign last = active & (cnt == CNT_LAST);
  assign busy = active | hold_valid;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: an MSB-first and an LSB-first instance driven
// with identical stimulus, checked every cycle against a word-queue model and
// against hand-computed literal sequences.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;

  logic rdy0, data0, last0, busy0;
  logic rdy1, data1, last1, busy1;

  int checks = 0;
  int errors = 0;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .data(data0), .last(last0), .busy(busy0)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .data(data1), .last(last1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words in flight (head is the one on the wire) and the bit
  // position within the head word.
  logic [W-1:0] wq[$];
  int unsigned  pos = 0;
  int           acc_cnt = 0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      wq.delete();
      pos = 0;
    end else begin
      acc = in_valid && (wq.size() < 2);
      if (wq.size() > 0) begin
        pos++;
        if (pos == W) begin
          void'(wq.pop_front());
          pos = 0;
        end
      end
      if (acc) begin
        wq.push_back(in_data);
        acc_cnt++;
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    logic [W-1:0] w;
    logic busy_e, last_e, d0_e, d1_e, rdy_e;
    if (chk_en) begin
      busy_e = (wq.size() > 0);
      w      = busy_e ? wq[0] : '0;
      last_e = busy_e && (pos == W - 1);
      d0_e   = busy_e ? w[W-1-pos] : 1'b0;
      d1_e   = busy_e ? w[pos] : 1'b0;
      rdy_e  = !rst && (wq.size() < 2);
      cmp("model_ready_msb", rdy0, rdy_e);
      cmp("model_ready_lsb", rdy1, rdy_e);
      cmp("model_data_msb", data0, d0_e);
      cmp("model_data_lsb", data1, d1_e);
      cmp("model_last_msb", last0, last_e);
      cmp("model_last_lsb", last1, last_e);
      cmp("model_busy_msb", busy0, busy_e);
      cmp("model_busy_lsb", busy1, busy_e);
      if (!busy0) cmp("idle_data_zero_msb", data0, 1'b0);
      if (!busy1) cmp("idle_data_zero_lsb", data1, 1'b0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0]   wa;
    logic [2*W-1:0] bb;
    int             prev;
    int             target;
    int             guard;

    // Reset with a word offered: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp("rst_ready", rdy0, 1'b0);
      cmp("rst_data", data0, 1'b0);
      cmp("rst_last", last0, 1'b0);
      cmp("rst_busy", busy0, 1'b0);
      next_cycle();
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    cmp("rel_ready", rdy0, 1'b1);
    cmp("rel_busy", busy0, 1'b0);

    // Single word 8'hA5.
    next_cycle();
    wa = 8'hA5;
    in_valid = 1'b1; in_data = wa;
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      cmp("a5_data_msb", data0, wa[W-1-i]);
      cmp("a5_data_lsb", data1, wa[i]);
      cmp("a5_last", last0, (i == W - 1) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    cmp("a5_end_data", data0, 1'b0);
    cmp("a5_end_busy", busy0, 1'b0);

    // Back-to-back 8'hF0, 8'h0F.
    next_cycle();
    bb = 16'b11110000_00001111;
    in_valid = 1'b1; in_data = 8'hF0;
    next_cycle();
    in_data = 8'h0F;
    for (int c = 1; c <= 2 * W; c++) begin
      @(negedge clk);
      cmp("b2b_data", data0, bb[2*W-c]);
      cmp("b2b_ready", rdy0, (c >= 2 && c <= W) ? 1'b0 : 1'b1);
      cmp("b2b_last", last0, (c == W || c == 2 * W) ? 1'b1 : 1'b0);
      next_cycle();
      if (c == 1) in_valid = 1'b0;
    end
    @(negedge clk);
    cmp("b2b_end_busy", busy0, 1'b0);

    // LSB-first single word 8'h01.
    next_cycle();
    wa = 8'h01;
    in_valid = 1'b1; in_data = wa;
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      cmp("lsb01_data", data1, (i == 0) ? 1'b1 : 1'b0);
      cmp("lsb01_last", last1, (i == W - 1) ? 1'b1 : 1'b0);
    end

    // Reset mid-word with a held word.
    repeat (3) next_cycle();
    in_valid = 1'b1; in_data = 8'hFF;
    next_cycle();
    in_data = 8'h3C;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    cmp("mid_held_ready", rdy0, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    cmp("mid_busy_msb", busy0, 1'b0);
    cmp("mid_busy_lsb", busy1, 1'b0);
    cmp("mid_ready", rdy0, 1'b1);
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      cmp("mid_quiet_msb", data0, 1'b0);
      cmp("mid_quiet_lsb", data1, 1'b0);
    end

    // Random words with random gaps.
    next_cycle();
    prev   = acc_cnt;
    target = acc_cnt + 1000;
    guard  = 0;
    while (acc_cnt < target && guard < 20000) begin
      next_cycle();
      guard++;
      if (acc_cnt != prev) begin
        prev = acc_cnt;
        in_valid = 1'b0;
      end
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
      end
    end
    in_valid = 1'b0;
    cmp("random_completed", (acc_cnt >= target) ? 1'b1 : 1'b0, 1'b1);
    repeat (3 * W) next_cycle();
    @(negedge clk);
    cmp("drain_busy", busy0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the single-bit `data` stream consumed by the downstream four-ones detector (`fsm2`). It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `data`. A one-word holding register lets back-to-back words stream without idle gaps. When no word is in flight, `data` is held at 0, so the downstream detector keeps its state.

## Interface
- `WIDTH`, default 8: word width in bits; must be ≥2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  upstream word present.
- `in_data`  input  WIDTH  upstream word; sampled only on accept.
- `in_ready`  output  1  block can accept a word this cycle.
- `data`  output  1  serial bit stream to the detector.
- `last`  output  1  high while `data` carries the final bit of a word.
- `busy`  output  1  a word is shifting or a word is held.

## Operation
- Internal state:
  - shift register `sr[WIDTH-1:0]`
  - bit counter `cnt` (clog2(WIDTH) bits)
  - `active` flag
  - holding register `hb[WIDTH-1:0]` with `hold_valid`
- Two control states:
  - IDLE (`active`=0)
  - SHIFT (`active`=1)
- Accept: occurs on a clock edge when `in_valid` & `in_ready`. `in_ready` = ~`hold_valid` & ~`rst`.
- "Shifter free at edge" means IDLE, or SHIFT with `cnt`==WIDTH-1 (last bit ends this cycle).
- Shifter load priority at each edge:
  1. Shifter free and `hold_valid`: load `hb` into `sr`, clear `hold_valid`. A word accepted on the same edge goes into `hb` (`hold_valid` stays 1).
  2. Shifter free, no `hold_valid`, accept: load `in_data` directly into `sr`.
  3. Shifter not free, accept: write `in_data` into `hb`, set `hold_valid`.
  4. Shifter free, nothing to load: go to IDLE.
- Any load sets `active`=1 and `cnt`=0.
- In SHIFT, each edge without a load does `cnt`+1 and shifts `sr` by one position toward the output end.
- Output bit in SHIFT:
  - MSB_FIRST=1: `data` = `sr[WIDTH-1]`; shift left, 0 filled at the LSB.
  - MSB_FIRST=0: `data` = `sr[0]`; shift right, 0 filled at the MSB.
- In IDLE, `data` = 0.
- `last` = `active` & (`cnt`==WIDTH-1).
- `busy` = `active` | `hold_valid`.
- All outputs are decoded from registers only. None has a combinational path from `in_valid` or `in_data`.
- Words are never dropped or reordered. `in_data` is don't-care when not accepted.

## Timing
- Reset: when `rst` is high at an edge, the next cycle has `active`=0, `hold_valid`=0, `cnt`=0, `sr`=0, `hb`=0.
  - Outputs then: `data`=0, `last`=0, `busy`=0.
  - `in_ready`=0 in any cycle with `rst`=1, so no accept occurs during reset.
  - `in_ready`=1 in the first cycle after `rst` falls.
- Reset mid-word: the in-flight word and the held word are discarded. No partial bits appear after reset.
- Latency: a word accepted at edge k into an idle shifter puts its first bit on `data` in the cycle after edge k. Its last bit is in cycle k+WIDTH-1 counting from that cycle, i.e. WIDTH consecutive cycles.
- Throughput: with `in_valid` held high, one word every WIDTH cycles with no gap between the last bit of word n and the first bit of word n+1.
  - `in_ready` is low from the edge that fills `hb` until the edge that drains it.
- Accept arriving on the final-bit edge with `hb` empty: loads directly (rule 2), no gap.
- Accept arriving on the final-bit edge with `hb` full: impossible, because `in_ready`=0.
- IDLE→SHIFT→IDLE: if no word is pending when the last bit completes, `data` returns to 0 and `busy` falls in the next cycle.
- Downstream coupling: each serial bit is visible to the detector for exactly one cycle. Idle-time 0s do not advance the detector.

## Test plan
- Reset and idle: assert `rst` for 3 cycles with `in_valid`=1 and `in_data`=8'hFF.
  - During reset: no accept; `data`=0, `last`=0, `busy`=0, `in_ready`=0.
  - First cycle after release: `in_ready`=1.
- Single word, MSB_FIRST=1: accept 8'hA5 when idle.
  - `data` = 1,0,1,0,0,1,0,1 on cycles 1..8 after the accept edge.
  - `last` high only on cycle 8; `data`=0 and `busy`=0 on cycle 9.
- Back-to-back: hold `in_valid`=1 with words 8'hF0 then 8'h0F.
  - 16 consecutive bits: 11110000 00001111, with no gap.
  - `in_ready` low from the accept of 8'h0F until cycle 8.
  - Downstream `fsm2` `flag` is high in cycle 5.
- LSB-first: with MSB_FIRST=0, accept 8'h01. `data` = 1 then seven 0s; `last` on cycle 8.
- Reset mid-operation: accept 8'hFF, then a second word into `hb`, then assert `rst` during bit 3.
  - Next cycle: `data`=0, `busy`=0, `hold_valid` cleared.
  - No remaining bits of either word appear after `rst` falls.
- Stall upstream: present `in_valid` pulses with random gaps and random data for 1000 words.
  - The reconstructed bit stream matches the accepted words in order.
  - `data`=0 whenever `busy`=0.
